// File: rtl/video_raster_tracker.sv
// ----------------------------------------------------------------------------
// video_raster_tracker
//
// Purpose:
//   Converts raw hsync/vsync/data-enable from a video timing generator into
//   registered raster state for a downstream pixel source: active x/y,
//   start-of-line / start-of-frame strobes and a frame counter. It also
//   delays the syncs and DE by a fixed amount so they line up with a pixel
//   source of known latency. For bring-up it measures line and frame
//   geometry and raises a sticky flag on any mismatch.
//
// Ports:
//   clk          pixel clock
//   resetn       asynchronous active-low reset
//   hsync_in     hsync from timing generator (active-high), delay line only
//   vsync_in     vsync from timing generator (active-high)
//   de_in        data enable from timing generator
//   err_clr      single-cycle pulse, clears geom_err
//   active       de_in delayed 1 cycle, qualifies x/y
//   x            active pixel index within the line
//   y            active line index within the frame
//   sol          start-of-line strobe (first active pixel)
//   sof          start-of-frame strobe (first pixel of first line)
//   frame        frame counter
//   hs_out       hsync_in delayed 1+SYNC_DELAY cycles
//   vs_out       vsync_in delayed 1+SYNC_DELAY cycles
//   de_out       de_in delayed 1+SYNC_DELAY cycles
//   line_len     active pixel count of last completed line
//   frame_lines  active line count of last completed frame
//   geom_err     sticky geometry mismatch
// ----------------------------------------------------------------------------
module video_raster_tracker #(
    parameter int unsigned X_BITS     = 12,
    parameter int unsigned Y_BITS     = 11,
    parameter int unsigned FRAME_BITS = 8,
    parameter int unsigned SYNC_DELAY = 2,
    parameter int unsigned H_ACTIVE   = 1280,
    parameter int unsigned V_ACTIVE   = 720
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  de_in,
    input  logic                  err_clr,
    output logic                  active,
    output logic [X_BITS-1:0]     x,
    output logic [Y_BITS-1:0]     y,
    output logic                  sol,
    output logic                  sof,
    output logic [FRAME_BITS-1:0] frame,
    output logic                  hs_out,
    output logic                  vs_out,
    output logic                  de_out,
    output logic [X_BITS-1:0]     line_len,
    output logic [Y_BITS-1:0]     frame_lines,
    output logic                  geom_err
);

    localparam int unsigned DL = 1 + SYNC_DELAY;

    // active_q doubles as the previous-cycle de_in for edge detection.
    logic                  active_q,      active_d;
    logic                  vs_prev_q,     vs_prev_d;
    logic [X_BITS-1:0]     x_q,           x_d;
    logic [Y_BITS-1:0]     y_q,           y_d;
    logic                  sol_q,         sol_d;
    logic                  sof_q,         sof_d;
    logic [FRAME_BITS-1:0] frame_q,       frame_d;
    logic                  first_line_q,  first_line_d;
    logic [X_BITS-1:0]     line_len_q,    line_len_d;
    logic [Y_BITS-1:0]     line_cnt_q,    line_cnt_d;
    logic [Y_BITS-1:0]     frame_lines_q, frame_lines_d;
    logic                  line_seen_q,   line_seen_d;
    logic                  locked_q,      locked_d;
    logic                  geom_err_q,    geom_err_d;
    logic [DL-1:0]         hs_dl_q,       hs_dl_d;
    logic [DL-1:0]         vs_dl_q,       vs_dl_d;
    logic [DL-1:0]         de_dl_q,       de_dl_d;

    logic              de_rise;
    logic              de_fall;
    logic              vs_rise;
    logic [X_BITS-1:0] x_inc;
    logic [Y_BITS-1:0] line_total;
    logic              line_fail;
    logic              frame_fail;

    always_comb begin
        de_rise    = de_in & ~active_q;
        de_fall    = ~de_in & active_q;
        vs_rise    = vsync_in & ~vs_prev_q;

        // x still holds the last pixel index on the de_fall cycle.
        x_inc      = x_q + X_BITS'(1);
        // A line ending in the same cycle as vsync rises belongs to the
        // frame being closed.
        line_total = line_cnt_q + Y_BITS'(de_fall);

        line_fail  = de_fall & line_seen_q & (x_inc != X_BITS'(H_ACTIVE));
        frame_fail = vs_rise & locked_q & (line_total != Y_BITS'(V_ACTIVE));

        active_d      = de_in;
        vs_prev_d     = vsync_in;
        x_d           = x_q;
        y_d           = y_q;
        sol_d         = de_rise;
        sof_d         = de_rise & (first_line_q | vs_rise);
        frame_d       = frame_q;
        first_line_d  = first_line_q;
        line_len_d    = line_len_q;
        line_cnt_d    = line_total;
        frame_lines_d = frame_lines_q;
        line_seen_d   = line_seen_q | de_rise;
        locked_d      = locked_q | vs_rise;

        if (de_rise) begin
            x_d = '0;
        end else if (de_in & active_q) begin
            x_d = x_inc;
        end

        if (de_rise) begin
            y_d = (first_line_q | vs_rise) ? '0 : y_q + Y_BITS'(1);
        end

        // vs_rise takes priority so a coincident de_rise leaves it set.
        if (vs_rise) begin
            first_line_d = 1'b1;
        end else if (de_rise) begin
            first_line_d = 1'b0;
        end

        if (de_fall) begin
            line_len_d = x_inc;
        end

        if (vs_rise) begin
            frame_d       = frame_q + FRAME_BITS'(1);
            frame_lines_d = line_total;
            line_cnt_d    = '0;
        end

        // A new failure outranks a coincident clear.
        geom_err_d = line_fail | frame_fail | (geom_err_q & ~err_clr);

        // Width cast drops the oldest stage; works for DL == 1 as well.
        hs_dl_d = DL'({hs_dl_q, hsync_in});
        vs_dl_d = DL'({vs_dl_q, vsync_in});
        de_dl_d = DL'({de_dl_q, de_in});
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            active_q      <= 1'b0;
            vs_prev_q     <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            sol_q         <= 1'b0;
            sof_q         <= 1'b0;
            frame_q       <= '0;
            first_line_q  <= 1'b0;
            line_len_q    <= '0;
            line_cnt_q    <= '0;
            frame_lines_q <= '0;
            line_seen_q   <= 1'b0;
            locked_q      <= 1'b0;
            geom_err_q    <= 1'b0;
            hs_dl_q       <= '0;
            vs_dl_q       <= '0;
            de_dl_q       <= '0;
        end else begin
            active_q      <= active_d;
            vs_prev_q     <= vs_prev_d;
            x_q           <= x_d;
            y_q           <= y_d;
            sol_q         <= sol_d;
            sof_q         <= sof_d;
            frame_q       <= frame_d;
            first_line_q  <= first_line_d;
            line_len_q    <= line_len_d;
            line_cnt_q    <= line_cnt_d;
            frame_lines_q <= frame_lines_d;
            line_seen_q   <= line_seen_d;
            locked_q      <= locked_d;
            geom_err_q    <= geom_err_d;
            hs_dl_q       <= hs_dl_d;
            vs_dl_q       <= vs_dl_d;
            de_dl_q       <= de_dl_d;
        end
    end

    assign active      = active_q;
    assign x           = x_q;
    assign y           = y_q;
    assign sol         = sol_q;
    assign sof         = sof_q;
    assign frame       = frame_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign geom_err    = geom_err_q;
    assign hs_out      = hs_dl_q[DL-1];
    assign vs_out      = vs_dl_q[DL-1];
    assign de_out      = de_dl_q[DL-1];

endmodule

// File: doc/video_raster_tracker.md
Name: video_raster_tracker

Overview:
- Sits directly downstream of the video timing generator and upstream of any pixel source such as a test pattern or framebuffer reader.
- Turns raw hsync/vsync/data_en into registered raster state for that pixel source:
  - active-pixel x/y coordinates
  - start-of-line and start-of-frame strobes
  - a frame counter
- Also provides a sync/DE delay line that re-aligns syncs to a pixel source with fixed latency.
- Also provides measured line/frame geometry with a sticky mismatch flag, used for bring-up of new video modes.

Parameters:
- X_BITS, 12, width of x and line_len.
- Y_BITS, 11, width of y, line counter and frame_lines.
- FRAME_BITS, 8, width of frame counter.
- SYNC_DELAY, 2, extra pixclk cycles (0..15) applied to hs_out/vs_out/de_out beyond x/y latency.
- H_ACTIVE, 1280, expected active pixels per line.
- V_ACTIVE, 720, expected active lines per frame.

Ports:
- clk  in  1  pixel clock.
- resetn  in  1  asynchronous active-low reset.
- hsync_in  in  1  hsync from timing generator, active-high.
- vsync_in  in  1  vsync from timing generator, active-high.
- de_in  in  1  data enable from timing generator.
- err_clr  in  1  single-cycle pulse; clears geom_err.
- active  out  1  de_in delayed 1 cycle; qualifies x/y.
- x  out  X_BITS  active pixel index within line.
- y  out  Y_BITS  active line index within frame.
- sol  out  1  start-of-line strobe (first active pixel).
- sof  out  1  start-of-frame strobe (first active pixel of first line).
- frame  out  FRAME_BITS  frame counter.
- hs_out  out  1  hsync_in delayed 1+SYNC_DELAY cycles.
- vs_out  out  1  vsync_in delayed 1+SYNC_DELAY cycles.
- de_out  out  1  de_in delayed 1+SYNC_DELAY cycles.
- line_len  out  X_BITS  active pixel count of last completed line.
- frame_lines  out  Y_BITS  active line count of last completed frame.
- geom_err  out  1  sticky geometry mismatch.

Behaviour:
- Reset: every output, counter, flag and delay-line register is 0. Edge detectors compare against prev=0, so vsync_in high on the first cycle after reset counts as a rising edge. Asserting resetn low mid-frame returns everything to 0 asynchronously.
- Edge events, each evaluated from the input at cycle t against its registered previous value:
  - de_rise = de_in & ~de_prev
  - de_fall = ~de_in & de_prev
  - vs_rise = vsync_in & ~vs_prev
- All x/y/strobe outputs have 1-cycle latency from the inputs.
- x:
  - de_rise → 0.
  - de_in & de_prev → x+1, wrapping modulo 2^X_BITS.
  - Otherwise hold.
- first_line flag:
  - Set on vs_rise.
  - Cleared on de_rise.
  - A vs_rise in the same cycle as a de_rise leaves it set.
- y:
  - de_rise with first_line set (or vs_rise the same cycle) → 0.
  - de_rise otherwise → y+1, wrapping.
  - Otherwise hold.
- sol = de_rise registered.
- sof = de_rise & (first_line | vs_rise), registered.
- frame: +1 on vs_rise, wraps modulo 2^FRAME_BITS.
- line_len: on de_fall, line_len ← x+1 (x holds last pixel index).
- line_cnt (internal):
  - +1 on de_fall.
  - On vs_rise: frame_lines ← line_cnt plus the de_fall of the same cycle if present; then line_cnt ← 0.
- Geometry checks:
  - line_seen flag: set on de_rise. A line check occurs on de_fall only if line_seen was set; this excludes a partial line already in progress at reset. A line check fails if x+1 ≠ H_ACTIVE.
  - locked flag: set on the first vs_rise. A frame check occurs on a vs_rise only when locked was already 1. A frame check fails if the computed frame_lines ≠ V_ACTIVE.
  - Any failure sets geom_err next cycle.
  - err_clr clears geom_err; a failure in the same cycle wins (geom_err stays 1).
- Delay line:
  - hs/vs/de shift through a 1+SYNC_DELAY stage register chain.
  - SYNC_DELAY=0 makes de_out identical to active.
- hsync_in feeds only the delay line; it does not affect counters.

Test Plan:
Bench uses H_ACTIVE=4, V_ACTIVE=3, SYNC_DELAY=2, with a synthetic timing source generating lines of 4 active + 3 blank cycles and 3 active lines per frame.

1. Reset release, drive two frames.
   - x steps 0,1,2,3 one cycle after each de_in.
   - y runs 0,1,2.
   - sof pulses only on frame's first pixel.
   - frame ends at 2.
   - line_len=4, frame_lines=3, geom_err=0.
2. Delay alignment: single de_in pulse at cycle 10 → active at 11, de_out at 13; hs_out/vs_out shifted identically.
3. Shorten one line to 3 active pixels → line_len=3, geom_err=1 next cycle; stays 1 through later good lines.
4. Pulse err_clr on a clean cycle → geom_err=0. Pulse err_clr coincident with a short-line de_fall → geom_err remains 1.
5. Frame with 4 active lines after lock → frame_lines=4, geom_err=1. First partial frame after reset (1 line) → no error.
6. Assert resetn low mid-line with x=2 → all outputs 0 immediately. Release with vsync_in high → frame=1 next cycle.
